// File: rtl/calc_pkg.sv
// Shared encodings, scancode constants and digit decode for the BCD calculator entry sequencer.
package calc_pkg;

  localparam int unsigned CODE_W = 9;
  localparam int unsigned BCD_W  = 8;
  localparam int unsigned RES_W  = 14;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPA  = 3'd1,
    ST_OPB  = 3'd2,
    ST_CALC = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  localparam logic [CODE_W-1:0] SC_PLUS     = 9'h079;
  localparam logic [CODE_W-1:0] SC_MINUS    = 9'h07B;
  localparam logic [CODE_W-1:0] SC_STAR     = 9'h07C;
  localparam logic [CODE_W-1:0] SC_ENTER    = 9'h05A;
  localparam logic [CODE_W-1:0] SC_KP_ENTER = 9'h15A;
  localparam logic [CODE_W-1:0] SC_ESC      = 9'h076;

  // Returns {is_digit, value}; top-row and keypad digits both map to 0..9.
  function automatic logic [4:0] digit_of(input logic [CODE_W-1:0] code);
    logic [4:0] r;
    case (code)
      9'h045, 9'h070: r = 5'h10;
      9'h016, 9'h069: r = 5'h11;
      9'h01E, 9'h072: r = 5'h12;
      9'h026, 9'h07A: r = 5'h13;
      9'h025, 9'h06B: r = 5'h14;
      9'h02E, 9'h073: r = 5'h15;
      9'h036, 9'h074: r = 5'h16;
      9'h03D, 9'h06C: r = 5'h17;
      9'h03E, 9'h075: r = 5'h18;
      9'h046, 9'h07D: r = 5'h19;
      default:        r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scancode_classify.sv
// Combinational classification of a PS/2 scancode into digit / operator / enter / escape.
module scancode_classify
  import calc_pkg::*;
(
  input  logic [8:0] last_change,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_op,
  output logic [1:0] op,
  output logic       is_enter,
  output logic       is_esc
);

  logic [4:0] dec;

  always_comb begin
    dec      = digit_of(last_change);
    is_digit = dec[4];
    digit    = dec[3:0];
    is_op    = 1'b0;
    op       = OP_ADD;
    case (last_change)
      SC_PLUS:  begin is_op = 1'b1; op = OP_ADD; end
      SC_MINUS: begin is_op = 1'b1; op = OP_SUB; end
      SC_STAR:  begin is_op = 1'b1; op = OP_MUL; end
      default:  ;
    endcase
    is_enter = (last_change == SC_ENTER) || (last_change == SC_KP_ENTER);
    is_esc   = (last_change == SC_ESC);
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keyboard sequencer for the 2-operand BCD calculator: collects A, op, B, starts the
// datapath, waits CALC_LAT cycles and latches the result.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned CALC_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic        key_make,
  input  logic [8:0]  last_change,
  input  logic [13:0] result_in,
  output logic [7:0]  opa_bcd,
  output logic [7:0]  opb_bcd,
  output logic [1:0]  op_sel,
  output logic        calc_start,
  output logic [13:0] result,
  output logic        result_valid,
  output logic [2:0]  curr_state
);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   opa_d, opb_d;
  logic [1:0]         op_d;
  logic [RES_W-1:0]   res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               b_seen_q, b_seen_d;
  logic               start_d, valid_d;

  logic       is_digit, is_op, is_enter, is_esc;
  logic [3:0] digit;
  logic [1:0] op;
  logic       ev;

  scancode_classify u_classify (
    .last_change (last_change),
    .is_digit    (is_digit),
    .digit       (digit),
    .is_op       (is_op),
    .op          (op),
    .is_enter    (is_enter),
    .is_esc      (is_esc)
  );

  assign ev         = key_valid && key_make;
  assign curr_state = state_q;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      opa_bcd      <= '0;
      opb_bcd      <= '0;
      op_sel       <= OP_ADD;
      result       <= '0;
      cnt_q        <= '0;
      b_seen_q     <= 1'b0;
      calc_start   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa_bcd      <= opa_d;
      opb_bcd      <= opb_d;
      op_sel       <= op_d;
      result       <= res_d;
      cnt_q        <= cnt_d;
      b_seen_q     <= b_seen_d;
      calc_start   <= start_d;
      result_valid <= valid_d;
    end
  end

  // Next-state and datapath-register updates; Esc overrides everything
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_bcd;
    opb_d    = opb_bcd;
    op_d     = op_sel;
    res_d    = result;
    cnt_d    = cnt_q;
    b_seen_d = b_seen_q;
    start_d  = 1'b0;
    valid_d  = 1'b0;

    if (ev && is_esc) begin
      state_d  = ST_IDLE;
      opa_d    = '0;
      opb_d    = '0;
      op_d     = OP_ADD;
      res_d    = '0;
      cnt_d    = '0;
      b_seen_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ev && is_digit) begin
            state_d = ST_OPA;
            opa_d   = {4'h0, digit};
          end
        end
        ST_OPA: begin
          if (ev && is_digit) begin
            opa_d = {opa_bcd[3:0], digit};
          end else if (ev && is_op) begin
            state_d  = ST_OPB;
            op_d     = op;
            opb_d    = '0;
            b_seen_d = 1'b0;
          end
        end
        ST_OPB: begin
          if (ev && is_digit) begin
            opb_d    = {opb_bcd[3:0], digit};
            b_seen_d = 1'b1;
          end else if (ev && is_op) begin
            op_d = op;
          end else if (ev && is_enter && b_seen_q) begin
            state_d = ST_CALC;
            start_d = 1'b1;
            cnt_d   = CNT_W'(CALC_LAT - 1);
          end
        end
        ST_CALC: begin
          if (cnt_q == '0) begin
            res_d   = result_in;
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          valid_d = 1'b1;
          if (ev && is_digit) begin
            state_d  = ST_OPA;
            opa_d    = {4'h0, digit};
            opb_d    = '0;
            op_d     = OP_ADD;
            b_seen_d = 1'b0;
            valid_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed self-checking bench for calc_entry_ctrl with CALC_LAT=2.
module tb_calc_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic        key_make;
  logic [8:0]  last_change;
  logic [13:0] result_in;
  logic [7:0]  opa_bcd;
  logic [7:0]  opb_bcd;
  logic [1:0]  op_sel;
  logic        calc_start;
  logic [13:0] result;
  logic        result_valid;
  logic [2:0]  curr_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  calc_entry_ctrl #(.CALC_LAT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_make     (key_make),
    .last_change  (last_change),
    .result_in    (result_in),
    .opa_bcd      (opa_bcd),
    .opb_bcd      (opb_bcd),
    .op_sel       (op_sel),
    .calc_start   (calc_start),
    .result       (result),
    .result_valid (result_valid),
    .curr_state   (curr_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (calc_start) n_start++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; one-cycle key event, returns at the next negedge.
  task automatic key(input logic [8:0] code, input logic make = 1'b1);
    key_valid   = 1'b1;
    key_make    = make;
    last_change = code;
    @(negedge clk);
    key_valid   = 1'b0;
    key_make    = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_state"}, 32'(curr_state), 32'd0);
    check({tag, "_opa"},   32'(opa_bcd),    32'h00);
    check({tag, "_opb"},   32'(opb_bcd),    32'h00);
    check({tag, "_op"},    32'(op_sel),     32'd0);
    check({tag, "_res"},   32'(result),     32'd0);
    check({tag, "_start"}, 32'(calc_start), 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
  endtask

  int starts_before;

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_make = 1'b0; last_change = '0; result_in = 14'd46;
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 12 + 34
    key(9'h016); key(9'h01E);
    check("a12_state", 32'(curr_state), 32'd1);
    key(9'h079); key(9'h026); key(9'h025);
    check("a_opa", 32'(opa_bcd), 32'h12);
    check("a_opb", 32'(opb_bcd), 32'h34);
    check("a_op",  32'(op_sel),  32'd0);
    check("a_state_opb", 32'(curr_state), 32'd2);
    starts_before = n_start;
    key(9'h05A);
    check("a_start1", 32'(calc_start), 32'd1);
    check("a_calc",   32'(curr_state), 32'd3);
    check("a_valid1", 32'(result_valid), 32'd0);
    @(negedge clk);
    check("a_start2", 32'(calc_start), 32'd0);
    check("a_valid2", 32'(result_valid), 32'd0);
    @(negedge clk);
    check("a_valid3", 32'(result_valid), 32'd1);
    check("a_result", 32'(result), 32'd46);
    check("a_done",   32'(curr_state), 32'd4);
    check("a_npulse", 32'(n_start - starts_before), 32'd1);

    // DONE -> new digit restarts operand A, keeps result register
    key(9'h026);
    check("d_state", 32'(curr_state), 32'd1);
    check("d_opa",   32'(opa_bcd), 32'h03);
    check("d_opb",   32'(opb_bcd), 32'h00);
    check("d_valid", 32'(result_valid), 32'd0);
    check("d_res",   32'(result), 32'd46);

    // 3,7,8,9 keeps last two digits; operator replaced in OPB
    key(9'h03D); key(9'h03E); key(9'h046);
    check("b_opa", 32'(opa_bcd), 32'h89);
    key(9'h07B); key(9'h07C); key(9'h02E);
    check("b_op",  32'(op_sel),  32'd2);
    check("b_opb", 32'(opb_bcd), 32'h05);
    result_in = 14'd445;
    key(9'h15A);
    check("b_calc", 32'(curr_state), 32'd3);
    @(negedge clk); @(negedge clk);
    check("b_res",   32'(result), 32'd445);
    check("b_valid", 32'(result_valid), 32'd1);

    // Esc from DONE clears everything, including result
    key(9'h076);
    check_cleared("esc_done");

    // Operator / Enter ignored in IDLE; Enter without B digit ignored
    key(9'h079); key(9'h05A);
    check("i_state", 32'(curr_state), 32'd0);
    check("i_opa",   32'(opa_bcd), 32'h00);
    starts_before = n_start;
    key(9'h025); key(9'h079); key(9'h05A);
    @(negedge clk); @(negedge clk);
    check("nb_state", 32'(curr_state), 32'd2);
    check("nb_start", 32'(n_start - starts_before), 32'd0);
    key(9'h076);

    // Releases ignored; keypad and top-row 2 both decode
    key(9'h016, 1'b0);
    check("rel_state", 32'(curr_state), 32'd0);
    key(9'h072);
    check("kp_opa", 32'(opa_bcd), 32'h02);
    key(9'h01E, 1'b0);
    check("rel_opa", 32'(opa_bcd), 32'h02);
    key(9'h01E);
    check("tr_opa", 32'(opa_bcd), 32'h22);

    // During CALC: digit ignored, Esc aborts on the sampling cycle
    key(9'h079); key(9'h069);
    result_in = 14'd999;
    key(9'h05A);
    key(9'h036);
    check("c_opb",   32'(opb_bcd), 32'h01);
    check("c_state", 32'(curr_state), 32'd3);
    key(9'h076);
    check_cleared("esc_calc");
    @(negedge clk);
    check("esc_calc_after", 32'(result_valid), 32'd0);

    // Async reset mid-CALC, observed before any clock edge
    key(9'h016); key(9'h079); key(9'h01E); key(9'h05A);
    check("r_calc", 32'(curr_state), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_cleared("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("r_after_state", 32'(curr_state), 32'd0);
    check("r_after_res",   32'(result), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
- Keyboard-driven sequencer for the 2-operand BCD calculator datapath (add/sub/mul units, display mux).
- Consumes decoded PS/2 scancode events and collects operand A, the operator and operand B as 2-digit BCD.
- Issues a start pulse to the arithmetic datapath, waits a fixed latency, then latches and presents the result.
- Sits between the keyboard decoder and the arithmetic/display blocks.

Parameters:
- CALC_LAT, 2, cycles from calc_start to result sampling; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- key_valid  input  1  one-cycle pulse when last_change updates
- key_make  input  1  1 = press (key_down[last_change]), 0 = release
- last_change  input  9  scancode; bit 8 = E0-extended
- result_in  input  14  datapath result for current opa/opb/op_sel
- opa_bcd  output  8  operand A, {tens, ones} BCD
- opb_bcd  output  8  operand B, {tens, ones} BCD
- op_sel  output  2  0 = add, 1 = sub, 2 = mul
- calc_start  output  1  one-cycle pulse on entering CALC
- result  output  14  latched result
- result_valid  output  1  high while in DONE
- curr_state  output  3  state encoding, for LEDs

Behaviour:
- Event = key_valid && key_make. Releases and all unlisted codes are ignored.
- Digit codes:
  - Top row: 0=0x45, 1=0x16, 2=0x1E, 3=0x26, 4=0x25, 5=0x2E, 6=0x36, 7=0x3D, 8=0x3E, 9=0x46.
  - Keypad: 0=0x70, 1=0x69, 2=0x72, 3=0x7A, 4=0x6B, 5=0x73, 6=0x74, 7=0x6C, 8=0x75, 9=0x7D.
- Operator codes: '+'=0x79, '-'=0x7B, '*'=0x7C.
- Enter = 0x05A or 0x15A. Esc = 0x076.
- Reset and Esc (in any state) act identically: state IDLE; opa, opb, op_sel, result, counter cleared; calc_start=0, result_valid=0.
- Digit entry into an operand: tens<=ones, ones<=digit. A third digit drops the old tens digit (keep last two).
- States: IDLE=0, OPA=1, OPB=2, CALC=3, DONE=4.
- IDLE:
  - digit -> OPA, opa={0,d}.
  - operator or Enter ignored.
- OPA:
  - digit shifts into opa.
  - operator -> OPB; op_sel latched; opb=00; b_seen=0.
  - Enter ignored.
- OPB:
  - digit shifts into opb; b_seen=1.
  - operator replaces op_sel, opb kept.
  - Enter with b_seen=1 -> CALC. Enter with b_seen=0 is ignored.
- CALC:
  - calc_start=1 on the first cycle only; counter loads CALC_LAT-1.
  - Counter decrements each cycle. The cycle it reads 0: result<=result_in, -> DONE.
  - result_valid rises exactly CALC_LAT+1 cycles after the Enter event cycle.
  - All key events except Esc are ignored.
- DONE:
  - result_valid=1; result held.
  - digit -> OPA with opa={0,d}, opb=00, op_sel=0, result_valid=0 (result register retained).
  - operator or Enter ignored.
- opa, opb and op_sel are stable from Enter until DONE is exited, so the combinational datapath is stable at sampling.
- Reset asserted mid-CALC aborts with no result latched.

Decomposition:
- Shared package calc_pkg holds:
  - state encodings;
  - op_sel encodings;
  - scancode constants;
  - function returning {is_digit, value[3:0]} for a 9-bit code.
- One sub-module, scancode_classify (combinational), maps last_change to is_digit/digit/is_op/op/is_enter/is_esc.
- The FSM, operand shift registers and latency counter stay in calc_entry_ctrl.

Test Plan:
- Reset, then keys 1,2,'+',3,4,Enter (CALC_LAT=2, result_in driven 46) -> opa=0x12, opb=0x34, op_sel=0; calc_start pulses 1 cycle; result_valid rises 3 cycles after Enter; result=46; curr_state ends at 4.
- Keys 7,8,9 -> opa=0x89. Then '-','*',5,Enter -> op_sel=2, opb=0x05.
- '+' then Enter in IDLE -> no change. Keys 4,'+',Enter -> stays OPB, calc_start never pulses.
- Release events (key_make=0) for digit codes -> no operand change. Keypad 0x72 and top-row 0x1E both enter digit 2.
- During CALC: key 6 -> ignored. Esc -> IDLE, all outputs zero, no result latched. Async rst mid-CALC -> same, applied without a clock edge.
- In DONE, key 3 -> state OPA, opa=0x03, opb=0x00, result_valid=0, result register unchanged.
